csr_file: RTL and testbench



---
 rtl/csr_file.sv | 141 ++++++++++++++
 tb/tb_csr_file.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file for the RV32I core.
// Sits after the decoder. It performs the atomic CSR read-modify-write and
// returns the old value for rd. It also holds the 64-bit cycle/instret
// counters and the trap/mret state that the fetch stage consumes.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   csr_adr           - CSR address (inst[31:20])
//   csr_op_ctr        - 0 write, 1 set, 2 clear, 3 none
//   csr_imm_en        - operand is zimm (rs1_adr) instead of rs1_data
//   csr_read_en       - old value is required on csr_rdata
//   rs1_adr, rs1_data - rs1 field / zimm, register-file rs1 value
//   inst_retire       - one instruction retires this cycle
//   irq_ext/timer/soft - level interrupt lines, reflected in mip
//   trap_en, trap_pc, trap_cause - trap entry request
//   mret              - return from trap
//   csr_rdata         - old CSR value (combinational)
//   csr_illegal       - unimplemented address or write to read-only CSR
//   mtvec_out, mepc_out, mie_global - state exported to fetch / irq logic
module csr_file #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_adr,
  input  logic [1:0]  csr_op_ctr,
  input  logic        csr_imm_en,
  input  logic        csr_read_en,
  input  logic [4:0]  rs1_adr,
  input  logic [31:0] rs1_data,
  input  logic        inst_retire,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        irq_soft,
  input  logic        trap_en,
  input  logic [31:0] trap_pc,
  input  logic [31:0] trap_cause,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_global
);

  logic        st_mie, st_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] old_val, opnd, nv;
  logic        adr_ok, wr_req, do_wr;

  // Old value mux; adr_ok flags implemented addresses.
  always_comb begin
    old_val = '0;
    adr_ok  = 1'b1;
    case (csr_adr)
      12'h300: old_val = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
      12'h304: old_val = mie_q;
      12'h305: old_val = mtvec_q;
      12'h340: old_val = mscratch_q;
      12'h341: old_val = mepc_q;
      12'h342: old_val = mcause_q;
      12'h344: old_val = {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_soft, 3'b0};
      12'hB00, 12'hC00: old_val = mcycle_q[31:0];
      12'hB80, 12'hC80: old_val = mcycle_q[63:32];
      12'hB02, 12'hC02: old_val = minstret_q[31:0];
      12'hB82, 12'hC82: old_val = minstret_q[63:32];
      default: adr_ok = 1'b0;
    endcase
  end

  assign opnd = csr_imm_en ? {27'b0, rs1_adr} : rs1_data;

  always_comb begin
    case (csr_op_ctr)
      2'd1:    nv = old_val | opnd;
      2'd2:    nv = old_val & ~opnd;
      default: nv = opnd;
    endcase
  end

  // Set/clear with rs1 = x0 (or zimm = 0) is a pure read and may target
  // read-only CSRs.
  assign wr_req      = (csr_op_ctr == 2'd0) ||
                       ((csr_op_ctr == 2'd1 || csr_op_ctr == 2'd2) && rs1_adr != 5'd0);
  assign csr_illegal = (csr_op_ctr != 2'd3) &&
                       (!adr_ok || (wr_req && csr_adr[11:10] == 2'b11));
  assign do_wr       = wr_req && !csr_illegal && !trap_en && !mret;
  assign csr_rdata   = (csr_read_en && csr_op_ctr != 2'd3) ? old_val : 32'h0;

  assign mtvec_out  = mtvec_q;
  assign mepc_out   = mepc_q;
  assign mie_global = st_mie;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST & ~32'd3;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      // A write to either half replaces it and holds the counter this cycle.
      if (do_wr && csr_adr == 12'hB00)      mcycle_q <= {mcycle_q[63:32], nv};
      else if (do_wr && csr_adr == 12'hB80) mcycle_q <= {nv, mcycle_q[31:0]};
      else                                   mcycle_q <= mcycle_q + 64'd1;

      if (do_wr && csr_adr == 12'hB02)      minstret_q <= {minstret_q[63:32], nv};
      else if (do_wr && csr_adr == 12'hB82) minstret_q <= {nv, minstret_q[31:0]};
      else if (inst_retire)                  minstret_q <= minstret_q + 64'd1;

      if (trap_en) begin
        mepc_q   <= trap_pc & ~32'd3;
        mcause_q <= trap_cause;
        st_mpie  <= st_mie;
        st_mie   <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end else if (do_wr) begin
        case (csr_adr)
          12'h300: begin
            st_mie  <= nv[3];
            st_mpie <= nv[7];
          end
          12'h304: mie_q      <= nv & 32'h0000_0888;
          12'h305: mtvec_q    <= nv & ~32'd3;
          12'h340: mscratch_q <= nv;
          12'h341: mepc_q     <= nv & ~32'd3;
          12'h342: mcause_q   <= nv;
          default: ;  // mip and counters: no effect / handled above
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_adr;
  logic [1:0]  csr_op_ctr;
  logic        csr_imm_en, csr_read_en;
  logic [4:0]  rs1_adr;
  logic [31:0] rs1_data;
  logic        inst_retire, irq_ext, irq_timer, irq_soft;
  logic        trap_en, mret;
  logic [31:0] trap_pc, trap_cause;
  logic [31:0] csr_rdata, mtvec_out, mepc_out;
  logic        csr_illegal, mie_global;

  int checks = 0;
  int failures = 0;

  csr_file #(.MTVEC_RST(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n), .csr_adr(csr_adr), .csr_op_ctr(csr_op_ctr),
    .csr_imm_en(csr_imm_en), .csr_read_en(csr_read_en), .rs1_adr(rs1_adr),
    .rs1_data(rs1_data), .inst_retire(inst_retire), .irq_ext(irq_ext),
    .irq_timer(irq_timer), .irq_soft(irq_soft), .trap_en(trap_en),
    .trap_pc(trap_pc), .trap_cause(trap_cause), .mret(mret),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .mtvec_out(mtvec_out),
    .mepc_out(mepc_out), .mie_global(mie_global)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive a CSR op and let combinational outputs settle.
  task automatic set_op(input logic [1:0] op, input logic [11:0] adr, input logic imm,
                        input logic [4:0] ra, input logic [31:0] d);
    csr_op_ctr = op; csr_adr = adr; csr_imm_en = imm;
    rs1_adr = ra; rs1_data = d; csr_read_en = 1'b1;
    #1;
  endtask

  // Pure read: CSRRS with rs1 = x0.
  task automatic rd(input logic [11:0] adr);
    set_op(2'd1, adr, 1'b0, 5'd0, 32'hFFFF_FFFF);
  endtask

  // Advance one edge, then return all controls to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    csr_op_ctr = 2'd3; csr_read_en = 1'b0; csr_imm_en = 1'b0;
    rs1_adr = '0; rs1_data = '0; trap_en = 1'b0; mret = 1'b0; inst_retire = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; csr_adr = '0; csr_op_ctr = 2'd3; csr_imm_en = 1'b0;
    csr_read_en = 1'b0; rs1_adr = '0; rs1_data = '0; inst_retire = 1'b0;
    irq_ext = 1'b0; irq_timer = 1'b0; irq_soft = 1'b0; trap_en = 1'b0;
    mret = 1'b0; trap_pc = '0; trap_cause = '0;
    tick(); tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_mtvec", mtvec_out, 32'h0000_1000);
    chk("rst_mepc", mepc_out, 32'h0);
    chk("rst_mie_global", {31'b0, mie_global}, 32'h0);
    chk("idle_rdata", csr_rdata, 32'h0);
    chk("idle_illegal", {31'b0, csr_illegal}, 32'h0);
    rd(12'hB00);
    chk("rst_mcycle", csr_rdata, 32'h0);
    chk("rst_mstatus_dummy_legal", {31'b0, csr_illegal}, 32'h0);
    tick();
    rd(12'h300);
    chk("rst_mstatus", csr_rdata, 32'h0000_1800);
    tick();

    // 1: CSRRW mscratch
    set_op(2'd0, 12'h340, 1'b0, 5'd3, 32'hDEAD_BEEF);
    chk("rw_mscratch_old", csr_rdata, 32'h0);
    tick();
    rd(12'h340);
    chk("rw_mscratch_new", csr_rdata, 32'hDEAD_BEEF);
    tick();

    // 2: CSRRSI / CSRRCI mstatus, and CSRRS with x0
    set_op(2'd1, 12'h300, 1'b1, 5'd8, 32'h0);
    chk("rsi_old", csr_rdata, 32'h0000_1800);
    tick();
    chk("rsi_mie_global", {31'b0, mie_global}, 32'h1);
    rd(12'h300);
    chk("rsi_mstatus", csr_rdata, 32'h0000_1808);
    tick();
    set_op(2'd2, 12'h300, 1'b1, 5'd8, 32'h0);
    tick();
    chk("rci_mie_global", {31'b0, mie_global}, 32'h0);
    set_op(2'd1, 12'h300, 1'b0, 5'd0, 32'hFFFF_FFFF);
    chk("rs_x0_old", csr_rdata, 32'h0000_1800);
    tick();
    rd(12'h300);
    chk("rs_x0_unchanged", csr_rdata, 32'h0000_1800);
    tick();
    set_op(2'd1, 12'h300, 1'b1, 5'd8, 32'h0);
    tick();

    // 3: trap (with a concurrent dropped write), then mret
    trap_en = 1'b1; trap_pc = 32'h0000_0107; trap_cause = 32'h8000_000B;
    set_op(2'd0, 12'h340, 1'b0, 5'd1, 32'h1234_5678);
    tick();
    chk("trap_mepc", mepc_out, 32'h0000_0104);
    chk("trap_mie_global", {31'b0, mie_global}, 32'h0);
    rd(12'h342);
    chk("trap_mcause", csr_rdata, 32'h8000_000B);
    tick();
    rd(12'h300);
    chk("trap_mstatus", csr_rdata, 32'h0000_1880);
    tick();
    rd(12'h340);
    chk("trap_drop_write", csr_rdata, 32'hDEAD_BEEF);
    tick();
    mret = 1'b1;
    tick();
    chk("mret_mie_global", {31'b0, mie_global}, 32'h1);
    rd(12'h300);
    chk("mret_mstatus", csr_rdata, 32'h0000_1888);
    tick();

    // 4: counter carry and write priority
    set_op(2'd0, 12'hB00, 1'b0, 5'd1, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00);
    chk("mcycle_written", csr_rdata, 32'hFFFF_FFFF);
    tick();
    rd(12'hB00);
    chk("mcycle_wrap_lo", csr_rdata, 32'h0);
    tick();
    rd(12'hB80);
    chk("mcycle_carry_hi", csr_rdata, 32'h1);
    tick();
    set_op(2'd0, 12'hB02, 1'b0, 5'd1, 32'd5);
    inst_retire = 1'b1;
    tick();
    inst_retire = 1'b1;
    rd(12'hB02);
    chk("minstret_write_wins", csr_rdata, 32'd5);
    tick();
    rd(12'hB02);
    chk("minstret_retire", csr_rdata, 32'd6);
    tick();

    // 5: illegal accesses
    set_op(2'd0, 12'hB00, 1'b0, 5'd1, 32'd100);
    tick();
    set_op(2'd0, 12'hC00, 1'b0, 5'd1, 32'h0000_AAAA);
    chk("ro_write_illegal", {31'b0, csr_illegal}, 32'h1);
    tick();
    rd(12'hB00);
    chk("ro_write_dropped", csr_rdata, 32'd101);
    tick();
    rd(12'hC00);
    chk("ro_read_legal", {31'b0, csr_illegal}, 32'h0);
    chk("ro_read_cycle", csr_rdata, 32'd102);
    tick();
    rd(12'h7C0);
    chk("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
    tick();
    csr_adr = 12'h7C0; #1;
    chk("unimpl_noop_legal", {31'b0, csr_illegal}, 32'h0);

    // mip is read-only state, but a write to it is legal
    irq_timer = 1'b1; irq_soft = 1'b1;
    rd(12'h344);
    chk("mip_read", csr_rdata, 32'h0000_0088);
    tick();
    set_op(2'd0, 12'h344, 1'b0, 5'd1, 32'hFFFF_FFFF);
    chk("mip_write_legal", {31'b0, csr_illegal}, 32'h0);
    tick();
    irq_timer = 1'b0; irq_soft = 1'b0;
    set_op(2'd0, 12'h305, 1'b0, 5'd1, 32'h0000_2003);
    tick();
    chk("mtvec_write", mtvec_out, 32'h0000_2000);

    // 6: reset overrides a concurrent trap and mtvec write
    rst_n = 1'b0;
    trap_en = 1'b1; trap_pc = 32'h0000_0208; trap_cause = 32'h0000_0002;
    set_op(2'd0, 12'h305, 1'b0, 5'd1, 32'h0000_4000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst2_mtvec", mtvec_out, 32'h0000_1000);
    chk("rst2_mepc", mepc_out, 32'h0);
    chk("rst2_mie_global", {31'b0, mie_global}, 32'h0);
    rd(12'hB00);
    chk("rst2_mcycle", csr_rdata, 32'h0);
    tick();
    rd(12'h340);
    chk("rst2_mscratch", csr_rdata, 32'h0);
    tick();
    rd(12'h342);
    chk("rst2_mcause", csr_rdata, 32'h0);
    tick();
    rd(12'h300);
    chk("rst2_mstatus", csr_rdata, 32'h0000_1800);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
